// File: rtl/aes_load_sequencer_pkg.sv
// aes_load_sequencer_pkg: shared field selects, FSM encoding and ASCII constants
package aes_load_sequencer_pkg;
  localparam logic [1:0] FLD_IV  = 2'd0;
  localparam logic [1:0] FLD_MSG = 2'd1;
  localparam logic [1:0] FLD_KEY = 2'd2;
  localparam logic [1:0] FLD_RND = 2'd3;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, DONE, ERR} state_t;
endpackage

// File: rtl/aes_load_sequencer_if.sv
// aes_load_sequencer_if: sequencer-to-AES-core load/result handshake
interface aes_load_sequencer_if #(
  parameter int DATA_W  = 16,
  parameter int ROUND_W = 4
);
  logic core_load;
  logic core_finish;
  logic [DATA_W-1:0] core_iv;
  logic [DATA_W-1:0] core_data;
  logic [DATA_W-1:0] core_key;
  logic [DATA_W-1:0] core_result;
  logic [ROUND_W-1:0] core_round;
  modport master(
    output core_load, core_iv, core_data, core_key, core_round,
    input  core_finish, core_result
  );
  modport slave(
    input  core_load, core_iv, core_data, core_key, core_round,
    output core_finish, core_result
  );
endinterface

// File: rtl/aes_load_sequencer_nib_to_ascii.sv
// nib_to_ascii: maps one hex nibble to its ASCII character 0-9 / A-F
module nib_to_ascii
  import aes_load_sequencer_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii
);
  always_comb ascii = nib < 4'd10 ? ASCII_0 + {4'd0, nib} : ASCII_A + {4'd0, nib} - 8'd10;
endmodule

// File: rtl/aes_load_sequencer.sv
// aes_load_sequencer: nibble-loaded AES operand registers with load/finish/timeout sequencing
module aes_load_sequencer
  import aes_load_sequencer_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ROUND_W     = 4,
  parameter int TIMEOUT_CYC = 1024
)(
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         wr_en,
  input  logic [1:0]                   wr_field,
  input  logic [$clog2(DATA_W/4)-1:0]  wr_nib,
  input  logic [3:0]                   wr_data,
  input  logic                         start,
  input  logic                         disp_req,
  aes_load_sequencer_if.master         core,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         oled_en,
  output logic [8*(DATA_W/4)-1:0]      ascii_out
);
  localparam int NIBS  = DATA_W / 4;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  state_t state, state_nx;
  logic [DATA_W-1:0] iv_q, msg_q, key_q, result_q;
  logic [ROUND_W-1:0] round_q;
  logic [CNT_W-1:0] cnt;
  logic idle_like, go, wr_ok, timeout, oled_q;
  always_comb begin
    idle_like = state inside {IDLE, DONE, ERR};
    go        = idle_like && start;
    wr_ok     = idle_like && wr_en && !start && int'(wr_nib) < NIBS;
    timeout   = cnt == CNT_W'(TIMEOUT_CYC - 1);
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  always_comb
    state_nx = go              ? (round_q == '0 ? ERR : LOAD)
             : state == LOAD   ? WAIT
             : state == WAIT   ? (core.core_finish ? DONE : timeout ? ERR : WAIT)
             : state;
  always_comb begin
    core.core_load  = state == LOAD;
    core.core_iv    = iv_q;
    core.core_data  = msg_q;
    core.core_key   = key_q;
    core.core_round = round_q;
    busy            = state inside {LOAD, WAIT};
    done            = state == DONE;
    err             = state == ERR;
    oled_en         = oled_q;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      iv_q     <= '0;
      msg_q    <= '0;
      key_q    <= '0;
      round_q  <= '0;
      result_q <= '0;
      cnt      <= '0;
      oled_q   <= 1'b0;
    end else begin
      oled_q <= state == DONE && disp_req;
      cnt    <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == WAIT && core.core_finish) result_q <= core.core_result;
      if (wr_ok && wr_field == FLD_IV)  iv_q[4*wr_nib +: 4]  <= wr_data;
      if (wr_ok && wr_field == FLD_MSG) msg_q[4*wr_nib +: 4] <= wr_data;
      if (wr_ok && wr_field == FLD_KEY) key_q[4*wr_nib +: 4] <= wr_data;
      if (wr_ok && wr_field == FLD_RND && wr_nib == '0) round_q <= ROUND_W'(wr_data);
    end
  for (genvar i = 0; i < NIBS; i++) begin : g_asc
    nib_to_ascii u_nib (.nib(result_q[4*i +: 4]), .ascii(ascii_out[8*i +: 8]));
  end
endmodule

// File: tb/tb_aes_load_sequencer.sv
// tb_aes_load_sequencer: directed bench checked against a transaction-level model
module tb_aes_load_sequencer;
  localparam int DW = 16, RW = 4, TO = 8, NB = DW / 4;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;
  logic wr_en, start, disp_req;
  logic [1:0] wr_field, wr_nib;
  logic [3:0] wr_data;
  logic busy, done, err, oled_en;
  logic [8*NB-1:0] ascii_out;
  aes_load_sequencer_if #(.DATA_W(DW), .ROUND_W(RW)) cif();
  aes_load_sequencer #(.DATA_W(DW), .ROUND_W(RW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_field(wr_field), .wr_nib(wr_nib),
    .wr_data(wr_data), .start(start), .disp_req(disp_req), .core(cif.master),
    .busy(busy), .done(done), .err(err), .oled_en(oled_en), .ascii_out(ascii_out)
  );
  logic w32_en, w24_en, zero;
  logic [1:0] w32_field, w24_field;
  logic [2:0] w32_nib, w24_nib;
  logic [3:0] w32_data, w24_data;
  logic b32, d32, e32, o32, b24, d24, e24, o24;
  logic [63:0] a32;
  logic [47:0] a24;
  aes_load_sequencer_if #(.DATA_W(32), .ROUND_W(RW)) cif32();
  aes_load_sequencer_if #(.DATA_W(24), .ROUND_W(RW)) cif24();
  aes_load_sequencer #(.DATA_W(32), .ROUND_W(RW), .TIMEOUT_CYC(TO)) dut32 (
    .clk(clk), .nrst(nrst), .wr_en(w32_en), .wr_field(w32_field), .wr_nib(w32_nib),
    .wr_data(w32_data), .start(zero), .disp_req(zero), .core(cif32.master),
    .busy(b32), .done(d32), .err(e32), .oled_en(o32), .ascii_out(a32)
  );
  aes_load_sequencer #(.DATA_W(24), .ROUND_W(RW), .TIMEOUT_CYC(TO)) dut24 (
    .clk(clk), .nrst(nrst), .wr_en(w24_en), .wr_field(w24_field), .wr_nib(w24_nib),
    .wr_data(w24_data), .start(zero), .disp_req(zero), .core(cif24.master),
    .busy(b24), .done(d24), .err(e24), .oled_en(o24), .ascii_out(a24)
  );
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  logic [DW-1:0] m_fld [4];
  logic [DW-1:0] m_res;
  int m_ph, m_wait;
  logic m_done, m_err, m_oled;
  always @(posedge clk or negedge nrst)
    if (!nrst) begin
      for (int k = 0; k < 4; k++) m_fld[k] <= '0;
      m_res <= '0; m_ph <= 0; m_wait <= 0;
      m_done <= 1'b0; m_err <= 1'b0; m_oled <= 1'b0;
    end else begin
      m_oled <= m_ph == 0 && m_done && disp_req;
      if (m_ph == 0) begin
        if (start) begin
          m_done <= 1'b0;
          m_err  <= m_fld[3] == 0;
          m_ph   <= m_fld[3] == 0 ? 0 : 1;
        end else if (wr_en && wr_nib < NB && (wr_field != 2'd3 || wr_nib == 0))
          m_fld[wr_field] <= wr_field == 2'd3 ? DW'(wr_data) & ((DW'(1) << RW) - 1)
                           : (m_fld[wr_field] & ~(DW'(15) << 4*wr_nib)) | (DW'(wr_data) << 4*wr_nib);
      end else if (m_ph == 1) begin
        m_ph <= 2; m_wait <= 0;
      end else if (cif.core_finish) begin
        m_res <= cif.core_result; m_done <= 1'b1; m_ph <= 0;
      end else if (m_wait + 1 == TO) begin
        m_err <= 1'b1; m_ph <= 0;
      end else m_wait <= m_wait + 1;
    end
  function automatic logic [8*NB-1:0] to_ascii(input logic [DW-1:0] v);
    int n;
    to_ascii = '0;
    for (int i = 0; i < NB; i++) begin
      n = int'((v >> 4*i) & DW'(15));
      to_ascii[8*i +: 8] = n < 10 ? 8'(48 + n) : 8'(55 + n);
    end
  endfunction
  always @(negedge clk) begin
    chk("m_load", cif.core_load, m_ph == 1);
    chk("m_busy", busy, m_ph != 0);
    chk("m_done", done, m_done);
    chk("m_err", err, m_err);
    chk("m_oled", oled_en, m_oled);
    chk("m_iv", cif.core_iv, m_fld[0]);
    chk("m_data", cif.core_data, m_fld[1]);
    chk("m_key", cif.core_key, m_fld[2]);
    chk("m_round", cif.core_round, m_fld[3][RW-1:0]);
    chk("m_ascii", ascii_out, to_ascii(m_res));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] f, input logic [1:0] n, input logic [3:0] d);
    wr_en = 1'b1; wr_field = f; wr_nib = n; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic wr_word(input logic [1:0] f, input logic [15:0] v);
    for (int i = 0; i < 4; i++) wr(f, 2'(i), v[4*i +: 4]);
  endtask
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    wr_en = 0; start = 0; disp_req = 0; wr_field = 0; wr_nib = 0; wr_data = 0; zero = 0;
    w32_en = 0; w32_field = 0; w32_nib = 0; w32_data = 0;
    w24_en = 0; w24_field = 0; w24_nib = 0; w24_data = 0;
    cif.core_finish = 0; cif.core_result = '0;
    cif32.core_finish = 0; cif32.core_result = '0;
    cif24.core_finish = 0; cif24.core_result = '0;
    repeat (2) tick();
    chk("rst_ascii", ascii_out, 32'h30303030);
    chk("rst_busy", busy, 1'b0);
    nrst = 1'b1;
    tick();
    wr(2'd0, 2'd0, 4'h1); wr(2'd0, 2'd1, 4'h2); wr(2'd0, 2'd2, 4'h3); wr(2'd0, 2'd3, 4'h4);
    chk("iv_4321", cif.core_iv, 16'h4321);
    chk("data_zero", cif.core_data, 16'h0);
    chk("key_zero", cif.core_key, 16'h0);
    wr_word(2'd2, 16'hBEEF);
    wr_word(2'd1, 16'h1234);
    wr(2'd3, 2'd0, 4'hA);
    chk("key_beef", cif.core_key, 16'hBEEF);
    chk("round_a", cif.core_round, 4'hA);
    go();
    chk("load_pulse", cif.core_load, 1'b1);
    tick();
    chk("load_single", cif.core_load, 1'b0);
    cif.core_finish = 1'b1; cif.core_result = 16'h00FF;
    tick();
    cif.core_finish = 1'b0;
    chk("done_set", done, 1'b1);
    chk("ascii_00ff", ascii_out, 32'h30304646);
    cif.core_finish = 1'b1; cif.core_result = 16'h1234;
    tick();
    cif.core_finish = 1'b0;
    chk("finish_ignored", ascii_out, 32'h30304646);
    disp_req = 1'b1;
    tick();
    disp_req = 1'b0;
    chk("oled_pulse", oled_en, 1'b1);
    tick();
    chk("oled_single", oled_en, 1'b0);
    wr(2'd3, 2'd0, 4'h0);
    go();
    chk("err_round0", err, 1'b1);
    chk("no_load_round0", cif.core_load, 1'b0);
    disp_req = 1'b1;
    tick();
    disp_req = 1'b0;
    chk("oled_in_err", oled_en, 1'b0);
    wr(2'd3, 2'd0, 4'h5);
    go();
    chk("recover_load", cif.core_load, 1'b1);
    chk("recover_err_clr", err, 1'b0);
    tick();
    wr(2'd1, 2'd0, 4'hF);
    chk("wait_write_drop", cif.core_data, 16'h1234);
    repeat (6) tick();
    chk("no_timeout_yet", err, 1'b0);
    tick();
    chk("timeout_err", err, 1'b1);
    chk("timeout_result_held", ascii_out, 32'h30304646);
    go();
    tick();
    #2 nrst = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_load", cif.core_load, 1'b0);
    chk("arst_iv", cif.core_iv, 16'h0);
    chk("arst_ascii", ascii_out, 32'h30303030);
    tick();
    nrst = 1'b1;
    repeat (3) tick();
    chk("no_load_after_rst", cif.core_load, 1'b0);
    wr(2'd3, 2'd0, 4'h3);
    wr_en = 1'b1; wr_field = 2'd1; wr_nib = 2'd0; wr_data = 4'h9;
    go();
    wr_en = 1'b0;
    chk("start_wins_load", cif.core_load, 1'b1);
    chk("start_wins_drop", cif.core_data, 16'h0);
    tick();
    cif.core_finish = 1'b1; cif.core_result = 16'hA5C3;
    tick();
    cif.core_finish = 1'b0;
    chk("ascii_a5c3", ascii_out, 32'h41354333);
    w32_en = 1'b1; w32_field = 2'd2; w32_nib = 3'd7; w32_data = 4'hF;
    tick();
    w32_nib = 3'd0; w32_data = 4'h5;
    tick();
    w32_en = 1'b0;
    chk("w32_key", cif32.core_key, 32'hF000_0005);
    w24_en = 1'b1; w24_field = 2'd2; w24_nib = 3'd6; w24_data = 4'hF;
    tick();
    w24_nib = 3'd7;
    tick();
    chk("w24_oob", cif24.core_key, 24'h0);
    w24_nib = 3'd5; w24_data = 4'hA;
    tick();
    w24_en = 1'b0;
    chk("w24_key", cif24.core_key, 24'hA0_0000);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
